booth2_mul_pp_stream_generator: RTL and testbench
=================================================

BOOTH2_MUL_PP_STREAM_GENERATOR -- requirements
Module: booth2_mul_pp_stream_generator

Interface
REQ-001 SHALL have parameter MUL_IN_WD, 32, operand width; even, >= 4.
REQ-002 SHALL have parameter PP_PER_CYC, 4, partial products per output beat; 1..NUM_PP.
REQ-003 SHALL have derived constants NUM_PP = MUL_IN_WD/2+1, PP_WD = MUL_IN_WD+2 and NUM_BEAT = ceil(NUM_PP/PP_PER_CYC).
REQ-004 SHALL have one clock and a synchronous, active-low reset, named clk and rstn as elsewhere in the codebase.
REQ-005 Ports: clk  in  1  clock; rstn  in  1  sync active-low reset.
REQ-006 Ports: flush_i  in  1  abort in-flight operation.
REQ-007 Ports: in_val  in  1  operands valid; in_rdy  out  1  operands accepted when in_val&in_rdy.
REQ-008 Ports: sgn_i  in  1  1 = signed, 0 = unsigned operands; ai  in  MUL_IN_WD  multiplicand; bi  in  MUL_IN_WD  multiplier.
REQ-009 Ports: out_val  out  1  beat valid; out_rdy  in  1  downstream accepts beat.
REQ-010 Ports: out_pp  out  PP_PER_CYC*PP_WD  partial products, slot 0 at LSBs.
REQ-011 Ports: out_s  out  PP_PER_CYC  per-slot negate flag (+1 at LSB downstream).
REQ-012 Ports: out_idx  out  clog2(NUM_BEAT)  beat number; out_last  out  1  final beat of operation.

Function
REQ-013 SHALL extend ai to MUL_IN_WD+1 bits (sign bit if sgn_i, else 0), and bi to PP_WD bits likewise, appending a 0 below bit 0.
REQ-014 Digit k (k = 0..NUM_PP-1) SHALL be taken from the triple (b[2k+1], b[2k], b[2k-1]) using radix-4 Booth encoding: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
REQ-015 For each digit, pp SHALL be 0, A or 2A, sign-extended to PP_WD bits; negative digits SHALL drive the bitwise inverse and s=1; zero and positive digits SHALL drive s=0.
REQ-016 SHALL register ai, bi and sgn_i on acceptance; later input changes SHALL NOT affect the operation.
REQ-017 SHALL use FSM states IDLE and BUSY: IDLE->BUSY on accept; BUSY->IDLE on last-beat handshake with no new accept; BUSY->BUSY on last-beat handshake with a simultaneous accept.
REQ-018 in_rdy SHALL be 1 in IDLE, and in BUSY only while out_val&out_rdy&out_last; this gives back-to-back operation with no bubble.
REQ-019 The first beat SHALL be valid the cycle after acceptance; beat j SHALL carry digits j*PP_PER_CYC onward, and out_idx SHALL equal j.
REQ-020 Unused slots in the final beat SHALL be pp=0 and s=0.
REQ-021 While out_val=1 and out_rdy=0, all out_* signals SHALL hold stable.
REQ-022 The beat counter SHALL advance only on out_val&out_rdy, and SHALL wrap to 0 after beat NUM_BEAT-1.
REQ-023 out_last SHALL be 1 exactly when out_idx = NUM_BEAT-1; if NUM_BEAT = 1, every beat SHALL be last.
REQ-024 flush_i SHALL return the FSM to IDLE and drive out_val=0 next cycle, zero the counter, and force in_rdy=0 that cycle; flush SHALL take precedence over accept and handshake.
REQ-025 Throughput SHALL be one beat per cycle when out_rdy is held high.

Reset
REQ-026 While rstn=0 at a clk edge, the block SHALL set: state IDLE, counter 0, out_val 0, out_pp 0, out_s 0, out_idx 0, out_last 0, and operand registers 0.
REQ-027 in_rdy SHALL be 0 during reset and 1 the cycle after rstn rises.
REQ-028 Reset mid-operation SHALL discard the operation with no further beats.

Structure
REQ-029 A shared package SHALL hold the Booth digit encoding constants, the FSM state encoding and the NUM_PP/PP_WD/NUM_BEAT derivation functions.
REQ-030 The single-digit encoder (triple plus extended A to pp and s) SHALL be one sub-module, booth2_mul_digit_encoder, instantiated PP_PER_CYC times.
REQ-031 Each instance SHALL be fed a mux-selected digit window indexed by the beat counter.

Verification (MUL_IN_WD=8, PP_PER_CYC=2: NUM_PP=5, PP_WD=10, NUM_BEAT=3)
REQ-032 Signed test: ai=8'h7F, bi=8'h03, out_rdy=1 -> beat0: pp0=10'h380 s0=1, pp1=10'h07F s1=0; beats 1 and 2 all zero; out_last on beat 2; the weighted sum equals 381.
REQ-033 Unsigned test: ai=8'hFF, bi=8'hFF -> pp0=10'h300 s0=1; pp4=10'h0FF (beat2 slot0) s=0; slots 1-3 and beat2 slot1 zero; the sum equals 65025.
REQ-034 Backpressure: hold out_rdy=0 for 5 cycles on beat1 -> beat1 outputs stable, out_idx=1 throughout, in_rdy=0.
REQ-035 Back-to-back: in_val held high with two operand sets -> second accepted on the first set's last-beat handshake; 6 consecutive valid beats.
REQ-036 Flush on beat1 with in_val=1 -> next cycle out_val=0, nothing accepted that cycle; accept the following cycle; the next beat has out_idx=0.
REQ-037 Reset mid-operation (rstn=0 during beat1) -> all outputs 0 next edge; no residual beats after release.

Source files
------------

// File: rtl/booth2_mul_pp_stream_generator_pkg.sv
// Shared definitions for the radix-4 Booth partial-product stream generator:
// digit encoding, FSM states and the width/beat-count derivations.
package booth2_mul_pp_stream_generator_pkg;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_digit_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int calc_num_pp(input int mul_in_wd);
        return mul_in_wd / 2 + 1;
    endfunction

    function automatic int calc_pp_wd(input int mul_in_wd);
        return mul_in_wd + 2;
    endfunction

    function automatic int calc_num_beat(input int mul_in_wd, input int pp_per_cyc);
        return (calc_num_pp(mul_in_wd) + pp_per_cyc - 1) / pp_per_cyc;
    endfunction

    // Triple is {b[2k+1], b[2k], b[2k-1]}.
    function automatic booth_digit_e booth_digit(input logic [2:0] triple);
        booth_digit_e d;
        case (triple)
            3'b001, 3'b010: d = DIG_POS1;
            3'b011:         d = DIG_POS2;
            3'b100:         d = DIG_NEG2;
            3'b101, 3'b110: d = DIG_NEG1;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth2_mul_pp_stream_generator_digit_encoder.sv
// Single Booth digit: turns one multiplier triple and the extended multiplicand
// into a sign-extended partial product plus its deferred +1 negate flag.
module booth2_mul_digit_encoder
    import booth2_mul_pp_stream_generator_pkg::*;
#(
    parameter  int MUL_IN_WD = 32,
    localparam int PP_WD     = calc_pp_wd(MUL_IN_WD)
) (
    input  logic [2:0]         triple,
    input  logic [MUL_IN_WD:0] a_ext,
    output logic [PP_WD-1:0]   pp,
    output logic               s
);

    logic [PP_WD-1:0] mag;
    logic             neg;

    // Negation is ones-complement here; the missing +1 travels as s.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (booth_digit(triple))
            DIG_POS1: mag = {a_ext[MUL_IN_WD], a_ext};
            DIG_POS2: mag = {a_ext, 1'b0};
            DIG_NEG1: begin
                mag = {a_ext[MUL_IN_WD], a_ext};
                neg = 1'b1;
            end
            DIG_NEG2: begin
                mag = {a_ext, 1'b0};
                neg = 1'b1;
            end
            default: ;
        endcase
        pp = neg ? ~mag : mag;
        s  = neg;
    end

endmodule

// File: rtl/booth2_mul_pp_stream_generator.sv
// Radix-4 Booth partial-product generator that streams PP_PER_CYC partial
// products per beat over a valid/ready interface.
module booth2_mul_pp_stream_generator
    import booth2_mul_pp_stream_generator_pkg::*;
#(
    parameter  int MUL_IN_WD  = 32,
    parameter  int PP_PER_CYC = 4,
    localparam int NUM_PP     = calc_num_pp(MUL_IN_WD),
    localparam int PP_WD      = calc_pp_wd(MUL_IN_WD),
    localparam int NUM_BEAT   = calc_num_beat(MUL_IN_WD, PP_PER_CYC),
    localparam int IDX_WD     = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush_i,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic                        sgn_i,
    input  logic [MUL_IN_WD-1:0]        ai,
    input  logic [MUL_IN_WD-1:0]        bi,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [PP_PER_CYC*PP_WD-1:0] out_pp,
    output logic [PP_PER_CYC-1:0]       out_s,
    output logic [IDX_WD-1:0]           out_idx,
    output logic                        out_last
);

    localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(NUM_BEAT - 1);

    state_e                 state, state_nxt;
    logic [IDX_WD-1:0]      cnt, cnt_nxt;
    logic [MUL_IN_WD:0]     a_reg;
    logic [PP_WD:0]         b_reg;
    logic                   accept;
    logic                   beat_done;
    logic                   is_last;
    logic [2:0]             triple [PP_PER_CYC];

    assign out_val   = (state == BUSY);
    assign is_last   = (cnt == LAST_IDX);
    assign out_last  = out_val && is_last;
    assign out_idx   = cnt;
    assign beat_done = out_val && out_rdy;
    assign in_rdy    = rstn && !flush_i && ((state == IDLE) || (beat_done && is_last));
    assign accept    = in_val && in_rdy;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            if (beat_done) begin
                cnt_nxt = is_last ? '0 : cnt + IDX_WD'(1);
            end
            case (state)
                IDLE:    if (accept) state_nxt = BUSY;
                BUSY:    if (beat_done && is_last && !accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // b_reg carries the implicit zero below bit 0 so digit k's triple is b_reg[2k+:3].
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                a_reg <= {sgn_i & ai[MUL_IN_WD-1], ai};
                b_reg <= {{2{sgn_i & bi[MUL_IN_WD-1]}}, bi, 1'b0};
            end
        end
    end

    // Slots past the last digit, or any slot while idle, see a zero triple.
    always_comb begin
        for (int i = 0; i < PP_PER_CYC; i++) begin
            triple[i] = 3'b000;
            if (out_val && ((int'(cnt) * PP_PER_CYC + i) < NUM_PP)) begin
                triple[i] = b_reg[2 * (int'(cnt) * PP_PER_CYC + i) +: 3];
            end
        end
    end

    for (genvar g = 0; g < PP_PER_CYC; g++) begin : g_enc
        booth2_mul_digit_encoder #(
            .MUL_IN_WD (MUL_IN_WD)
        ) u_enc (
            .triple (triple[g]),
            .a_ext  (a_reg),
            .pp     (out_pp[g*PP_WD +: PP_WD]),
            .s      (out_s[g])
        );
    end

endmodule

// File: tb/tb_booth2_mul_pp_stream_generator.sv
// Self-checking bench: directed and random operand streams scored against an
// arithmetic Booth-digit model and the full product.
module tb_booth2_mul_pp_stream_generator;

    localparam int W   = 8;
    localparam int P   = 2;
    localparam int NPP = 5;
    localparam int PW  = 10;
    localparam int NB  = 3;

    typedef struct packed {
        logic [P*PW-1:0] pp;
        logic [P-1:0]    s;
        logic [1:0]      idx;
        logic            last;
        longint          prod;
    } beat_t;

    logic            clk;
    logic            rstn;
    logic            flush_i;
    logic            in_val;
    logic            in_rdy;
    logic            sgn_i;
    logic [W-1:0]    ai;
    logic [W-1:0]    bi;
    logic            out_val;
    logic            out_rdy;
    logic [P*PW-1:0] out_pp;
    logic [P-1:0]    out_s;
    logic [1:0]      out_idx;
    logic            out_last;

    int     checks   = 0;
    int     failures = 0;
    beat_t  exp_q[$];
    longint obs_sum  = 0;

    booth2_mul_pp_stream_generator #(
        .MUL_IN_WD  (W),
        .PP_PER_CYC (P)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .flush_i  (flush_i),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .sgn_i    (sgn_i),
        .ai       (ai),
        .bi       (bi),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_pp   (out_pp),
        .out_s    (out_s),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int boothBit(input int b, input int pos);
        return (pos < 0) ? 0 : ((b >>> pos) & 1);
    endfunction

    // Digit value d = b[2k-1] + b[2k] - 2*b[2k+1]; pp = d*A, or ~(|d|*A) when negative.
    function automatic void pushOperation(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        int    av, bv, d, v, k;
        beat_t bt;
        av = $signed({{24{sg & a[W-1]}}, a});
        bv = $signed({{24{sg & b[W-1]}}, b});
        for (int j = 0; j < NB; j++) begin
            bt      = '0;
            bt.idx  = 2'(j);
            bt.last = (j == NB - 1);
            bt.prod = longint'(av) * longint'(bv);
            for (int sl = 0; sl < P; sl++) begin
                k = j * P + sl;
                if (k < NPP) begin
                    d = boothBit(bv, 2*k - 1) + boothBit(bv, 2*k) - 2 * boothBit(bv, 2*k + 1);
                    v = (d < 0) ? ~((-d) * av) : d * av;
                    bt.pp[sl*PW +: PW] = v[PW-1:0];
                    bt.s[sl]           = (d < 0);
                end
            end
            exp_q.push_back(bt);
        end
    endfunction

    // Scoreboard: predicts out_val and in_rdy from the expected-beat queue.
    always @(negedge clk) begin
        beat_t  h;
        bit     exp_rdy;
        longint term;
        int     k;
        if (!rstn || flush_i) begin
            checkOutput("in_rdy_blocked", {63'b0, in_rdy}, 64'd0);
            exp_q.delete();
            obs_sum = 0;
        end else begin
            exp_rdy = (exp_q.size() == 0) || (out_rdy && exp_q[0].last);
            checkOutput("out_val", {63'b0, out_val}, {63'b0, exp_q.size() != 0});
            checkOutput("in_rdy", {63'b0, in_rdy}, {63'b0, exp_rdy});
            if (out_val && exp_q.size() != 0) begin
                h = exp_q[0];
                checkOutput("out_pp", {44'b0, out_pp}, {44'b0, h.pp});
                checkOutput("out_s", {62'b0, out_s}, {62'b0, h.s});
                checkOutput("out_idx", {62'b0, out_idx}, {62'b0, h.idx});
                checkOutput("out_last", {63'b0, out_last}, {63'b0, h.last});
                if (out_rdy) begin
                    for (int j = 0; j < P; j++) begin
                        k = int'(h.idx) * P + j;
                        if (k < NPP) begin
                            term = longint'($signed(out_pp[j*PW +: PW])) + longint'({63'b0, out_s[j]});
                            obs_sum += term * (longint'(1) << (2 * k));
                        end
                    end
                    void'(exp_q.pop_front());
                    if (h.last) begin
                        checkOutput("product", obs_sum, h.prod);
                        obs_sum = 0;
                    end
                end
            end
            if (in_val && exp_rdy) pushOperation(ai, bi, sgn_i);
        end
    end

    task automatic applyStimulus(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sg, input logic ordy, input logic fl);
        in_val  = iv;
        ai      = a;
        bi      = b;
        sgn_i   = sg;
        out_rdy = ordy;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
        bit acc = 0;
        int n   = 0;
        in_val = 1'b1;
        ai     = a;
        bi     = b;
        sgn_i  = sg;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        in_val = 1'b0;
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int n);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        flush_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcount;
        bit acc;
        rstn    = 1'b0;
        flush_i = 1'b0;
        in_val  = 1'b0;
        sgn_i   = 1'b0;
        ai      = '0;
        bi      = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_val", {63'b0, out_val}, 64'd0);
        checkOutput("rst_out_pp", {44'b0, out_pp}, 64'd0);
        checkOutput("rst_out_s", {62'b0, out_s}, 64'd0);
        checkOutput("rst_out_idx", {62'b0, out_idx}, 64'd0);
        checkOutput("rst_out_last", {63'b0, out_last}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rdy_after_rst", {63'b0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] signed 0x7F * 0x03");
        runOp(8'h7F, 8'h03, 1'b1);
        @(negedge clk);
        checkOutput("sgn_beat0_pp", {44'b0, out_pp}, {44'b0, 10'h07F, 10'h380});
        checkOutput("sgn_beat0_s", {62'b0, out_s}, 64'd1);
        drain(5);

        $display("[TB] unsigned 0xFF * 0xFF");
        runOp(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        checkOutput("uns_beat0_pp", {44'b0, out_pp}, {44'b0, 10'h000, 10'h300});
        checkOutput("uns_beat0_s", {62'b0, out_s}, 64'd1);
        drain(5);

        $display("[TB] backpressure on beat1");
        runOp(8'hA5, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_idx", {62'b0, out_idx}, 64'd1);
            checkOutput("bp_in_rdy", {63'b0, in_rdy}, 64'd0);
            @(posedge clk);
            #1;
        end
        drain(5);

        $display("[TB] back-to-back operations");
        runOp(8'h12, 8'h9B, 1'b1);
        in_val = 1'b1;
        ai     = 8'hC3;
        bi     = 8'h5E;
        sgn_i  = 1'b0;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_val) vcount++;
            acc = in_val && in_rdy;
            @(posedge clk);
            #1;
            if (acc) in_val = 1'b0;
        end
        checkOutput("b2b_valid_beats", 64'(vcount), 64'd6);
        drain(5);

        $display("[TB] flush on beat1");
        runOp(8'h81, 8'h77, 1'b1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        in_val  = 1'b1;
        ai      = 8'h0D;
        bi      = 8'hE2;
        sgn_i   = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_val", {63'b0, out_val}, 64'd0);
        checkOutput("flush_rdy_next", {63'b0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;
        in_val = 1'b0;
        @(negedge clk);
        checkOutput("flush_new_val", {63'b0, out_val}, 64'd1);
        checkOutput("flush_new_idx", {62'b0, out_idx}, 64'd0);
        drain(5);

        $display("[TB] reset mid-operation");
        runOp(8'h6B, 8'hD4, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rdy", {63'b0, in_rdy}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_val", {63'b0, out_val}, 64'd0);
        checkOutput("midrst_pp", {44'b0, out_pp}, 64'd0);
        checkOutput("midrst_s", {62'b0, out_s}, 64'd0);
        checkOutput("midrst_idx", {62'b0, out_idx}, 64'd0);
        checkOutput("midrst_last", {63'b0, out_last}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post_rst_no_beat", {63'b0, out_val}, 64'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 39) == 0));
        end
        drain(10);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
